// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: packs opcode, register/function fields and a full
// immediate into one instruction word, flags bad immediates and tags each word with its address.
module inst_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [2:0]        out_err_code,
  output logic [15:0]       err_cnt
);

  localparam int unsigned CNT_W = 16;

  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_OPCODE = 3'd1;
  localparam logic [2:0] ERR_RANGE  = 3'd2;
  localparam logic [2:0] ERR_ALIGN  = 3'd3;
  localparam logic [2:0] ERR_ULOW   = 3'd4;

  logic              accept;
  logic              handoff;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       enc_inst;
  logic [2:0]        enc_code;
  logic              imm_fits_12;
  logic              imm_fits_13;
  logic              imm_fits_21;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  // Upper immediate bits must all replicate the format's sign bit.
  assign imm_fits_12 = (&in_imm[31:11]) || (~|in_imm[31:11]);
  assign imm_fits_13 = (&in_imm[31:12]) || (~|in_imm[31:12]);
  assign imm_fits_21 = (&in_imm[31:20]) || (~|in_imm[31:20]);

  // Field packing and immediate checks; errored words keep their truncated fields.
  always_comb begin
    enc_inst = '0;
    enc_code = ERR_NONE;
    case (in_opcode)
      OP_OPIMM, OP_LOAD, OP_JALR: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (!imm_fits_12) enc_code = ERR_RANGE;
      end
      OP_STORE: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (!imm_fits_12) enc_code = ERR_RANGE;
      end
      OP_BRANCH: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        if (in_imm[0])         enc_code = ERR_ALIGN;
        else if (!imm_fits_13) enc_code = ERR_RANGE;
      end
      OP_JAL: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (in_imm[0])         enc_code = ERR_ALIGN;
        else if (!imm_fits_21) enc_code = ERR_RANGE;
      end
      OP_LUI, OP_AUIPC: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        if (|in_imm[11:0]) enc_code = ERR_ULOW;
      end
      OP_OP: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      default: begin
        enc_inst = '0;
        enc_code = ERR_OPCODE;
      end
    endcase
  end

  // A clear coincident with an accept gives that word the base address.
  assign word_addr = clr ? BASE_ADDR : addr_cnt;

  // Output stage: reload on accept, drain on handoff, hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_inst     <= '0;
      out_addr     <= '0;
      out_err      <= 1'b0;
      out_err_code <= ERR_NONE;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_inst     <= enc_inst;
      out_addr     <= word_addr;
      out_err      <= (enc_code != ERR_NONE);
      out_err_code <= enc_code;
    end else if (handoff) begin
      out_valid    <= 1'b0;
    end
  end

  // Address counter and saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_cnt <= BASE_ADDR;
      err_cnt  <= '0;
    end else begin
      if (accept)   addr_cnt <= word_addr + ADDR_W'(4);
      else if (clr) addr_cnt <= BASE_ADDR;

      if (clr)
        err_cnt <= '0;
      else if (handoff && out_err && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed scenarios plus a randomized run scored against
// an arithmetic reference model of the encoding rules.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [2:0]  out_err_code;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
    logic [2:0]  code;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_addr;
  logic [15:0] m_errcnt;

  inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .out_err_code(out_err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference encoder built from signed ranges and shift/mask arithmetic.
  function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] imm,
                                     output logic [31:0] inst, output logic [2:0] code);
    int s;
    bit [31:0] u, rdv, r1, r2, fv3, fv7, opv, common;
    s = $signed(imm);
    u = imm; rdv = 32'(rd); r1 = 32'(rs1); r2 = 32'(rs2);
    fv3 = 32'(f3); fv7 = 32'(f7); opv = 32'(op);
    common = (r1 << 15) | (fv3 << 12) | opv;
    inst = 32'h0;
    code = 3'd0;
    case (op)
      7'h13, 7'h03, 7'h67: begin
        inst = ((u & 32'hFFF) << 20) | common | (rdv << 7);
        if (s < -2048 || s > 2047) code = 3'd2;
      end
      7'h23: begin
        inst = (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | common | ((u & 32'h1F) << 7);
        if (s < -2048 || s > 2047) code = 3'd2;
      end
      7'h63: begin
        inst = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r2 << 20) | common |
               (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7);
        if (u % 2 != 0) code = 3'd3;
        else if (s < -4096 || s > 4095) code = 3'd2;
      end
      7'h6F: begin
        inst = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
               (((u >> 12) & 32'hFF) << 12) | (rdv << 7) | opv;
        if (u % 2 != 0) code = 3'd3;
        else if (s < -1048576 || s > 1048575) code = 3'd2;
      end
      7'h37, 7'h17: begin
        inst = (u & 32'hFFFFF000) | (rdv << 7) | opv;
        if (u % 4096 != 0) code = 3'd4;
      end
      7'h33: inst = (fv7 << 25) | (r2 << 20) | common | (rdv << 7);
      default: begin
        inst = 32'h0;
        code = 3'd1;
      end
    endcase
  endfunction

  // Scoreboard: at each negedge, check the stage against the model, then apply the coming edge.
  always @(negedge clk) begin
    logic        exp_ready;
    logic [31:0] e_inst;
    logic [2:0]  e_code;
    logic [31:0] a;
    if (!rst_n) begin
      q.delete();
      m_addr   = 32'h0;
      m_errcnt = 16'h0;
    end else begin
      exp_ready = (q.size() == 0) || out_ready;
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL sb_in_ready got=%b exp=%b t=%0t", in_ready, exp_ready, $time);
      end
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL sb_out_valid got=%b exp=%b t=%0t", out_valid, q.size() != 0, $time);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_inst !== q[0].inst || out_addr !== q[0].addr ||
            out_err !== q[0].err || out_err_code !== q[0].code) begin
          errors++;
          $display("FAIL sb_word got=%h@%h err=%b code=%0d exp=%h@%h err=%b code=%0d t=%0t",
                   out_inst, out_addr, out_err, out_err_code,
                   q[0].inst, q[0].addr, q[0].err, q[0].code, $time);
        end
      end
      checks++;
      if (err_cnt !== m_errcnt) begin
        errors++; $display("FAIL sb_err_cnt got=%0d exp=%0d t=%0t", err_cnt, m_errcnt, $time);
      end
      if (out_ready && q.size() != 0) begin
        if (q[0].err && m_errcnt != 16'hFFFF) m_errcnt++;
        void'(q.pop_front());
      end
      if (clr) m_errcnt = 16'h0;
      if (in_valid && exp_ready) begin
        ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, e_inst, e_code);
        a = clr ? 32'h0 : m_addr;
        q.push_back('{inst: e_inst, addr: a, err: (e_code != 3'd0), code: e_code});
        m_addr = a + 32'd4;
      end else if (clr) begin
        m_addr = 32'h0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 ||
        out_err_code !== 3'd0 || err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset got v=%b inst=%h err=%b code=%0d cnt=%0d exp all zero",
               out_valid, out_inst, out_err, out_err_code, err_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h00500093 || out_addr !== 32'h0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL addi got v=%b inst=%h addr=%h err=%b exp v=1 inst=00500093 addr=0 err=0",
               out_valid, out_inst, out_addr, out_err);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    clr = 1'b1;
    drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    clr = 1'b0;
    checks++;
    if (out_inst !== 32'h0020A423 || out_addr !== 32'h0) begin
      errors++; $display("FAIL b2b_sw got=%h@%h exp=0020a423@0", out_inst, out_addr);
    end
    drive(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'hFE000EE3 || out_addr !== 32'h4) begin
      errors++; $display("FAIL b2b_beq got=%h@%h v=%b exp=fe000ee3@4", out_inst, out_addr, out_valid);
    end
    tick();
  endtask

  task automatic test_imm_checks();
    logic [6:0]  ops [0:4];
    logic [4:0]  rds [0:4];
    logic [31:0] imms [0:4];
    logic [31:0] insts [0:4];
    logic [2:0]  codes [0:4];
    ops   = '{7'h6F, 7'h6F, 7'h13, 7'h37, 7'h37};
    rds   = '{5'd1, 5'd1, 5'd1, 5'd5, 5'd5};
    imms  = '{32'h800, 32'h3, 32'h800, 32'h12345000, 32'h12345001};
    insts = '{32'h001000EF, 32'h002000EF, 32'h80000093, 32'h123452B7, 32'h123452B7};
    codes = '{3'd0, 3'd3, 3'd2, 3'd0, 3'd4};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], rds[i], 5'd0, 5'd0, 3'd0, 7'd0, imms[i]);
      tick();
      checks++;
      if (out_inst !== insts[i] || out_err_code !== codes[i] || out_err !== (codes[i] != 3'd0)) begin
        errors++;
        $display("FAIL imm_check%0d got inst=%h code=%0d err=%b exp inst=%h code=%0d",
                 i, out_inst, out_err_code, out_err, insts[i], codes[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_bad_opcode();
    out_ready = 1'b1; clr = 1'b1; in_valid = 1'b0;
    tick();
    clr = 1'b0; out_ready = 1'b0;
    drive(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd2, 32'h0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0 || out_err !== 1'b1 ||
        out_err_code !== 3'd1 || err_cnt !== 16'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_opcode got v=%b inst=%h err=%b code=%0d cnt=%0d rdy=%b exp 1 0 1 1 0 0",
               out_valid, out_inst, out_err, out_err_code, err_cnt, in_ready);
    end
    tick();
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++; $display("FAIL err_cnt_stalled got=%0d exp=0", err_cnt);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (err_cnt !== 16'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL err_cnt_handoff got cnt=%0d v=%b exp cnt=1 v=0", err_cnt, out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; clr = 1'b1;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    clr = 1'b0;
    drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_inst !== 32'h00500093 || out_addr !== 32'h0) begin
        errors++;
        $display("FAIL stall%0d got rdy=%b inst=%h addr=%h exp rdy=0 inst=00500093 addr=0",
                 i, in_ready, out_inst, out_addr);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_inst !== 32'h0020A423 || out_addr !== 32'h4) begin
      errors++; $display("FAIL drain_b got=%h@%h exp=0020a423@4", out_inst, out_addr);
    end
    drive(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    tick();
    checks++;
    if (out_inst !== 32'h123452B7 || out_addr !== 32'h8) begin
      errors++; $display("FAIL drain_c got=%h@%h exp=123452b7@8", out_inst, out_addr);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    rst_n = 1'b0;
    drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    checks++;
    if (out_valid !== 1'b0 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_midflight got v=%b cnt=%0d exp v=0 cnt=0", out_valid, err_cnt);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (out_inst !== 32'h0020A423 || out_addr !== 32'h0) begin
      errors++; $display("FAIL after_reset got=%h@%h exp=0020a423@0", out_inst, out_addr);
    end
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    clr = 1'b1;
    drive(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    tick();
    clr = 1'b0;
    checks++;
    if (out_inst !== 32'h123452B7 || out_addr !== 32'h0) begin
      errors++; $display("FAIL clr_accept got=%h@%h exp=123452b7@0", out_inst, out_addr);
    end
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    checks++;
    if (out_addr !== 32'h4) begin
      errors++; $display("FAIL clr_next_addr got=%h exp=4", out_addr);
    end
    in_valid = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] e [0:11];
    logic [31:0] r;
    e = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4096,
          32'hFFFFF000, 32'hFFFFEFFE, 32'h000FFFFE, 32'h00100000, 32'hFFF00000, 32'hFFEFFFFE};
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 4095)) - 32'd2048;
      1: return r;
      2: return r & 32'hFFFFF000;
      3: return e[$urandom_range(0, 11)];
      4: return 32'($signed(r) >>> $urandom_range(8, 22)) & ~32'($urandom_range(0, 1));
      default: return 32'($urandom_range(0, 8191)) - 32'd4096;
    endcase
  endfunction

  task automatic test_random();
    logic [6:0] ops [0:8];
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      in_opcode = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      in_imm    = rand_imm();
      tick();
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_imm_checks();
    test_bad_opcode();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RV32I instruction encoder; the inverse of the immediate-generation path in decode.
- Accepts an opcode, register fields, function fields and a full 32-bit immediate, and packs them into a 32-bit instruction word.
- Checks that the immediate fits the format and is correctly aligned; tags each emitted word with a sequential instruction-memory address.
- Used by the self-test program loader and by the verification assembler path.

Parameters:
- ADDR_W, 32, width of the emitted instruction address.
- BASE_ADDR, 32'h0000_0000, first address after reset or clear.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- clr  in  1  synchronous clear: address back to BASE_ADDR, err_cnt to 0; the output register is not affected
- in_valid  in  1  input word valid
- in_ready  out  1  encoder can accept an input word
- in_opcode  in  7  opcode
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_imm  in  32  full signed immediate (byte offset for B and J)
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the output word
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_W  address of out_inst
- out_err  out  1  encoding error on out_inst
- out_err_code  out  3  0 none, 1 bad opcode, 2 immediate out of range, 3 misaligned, 4 U low bits nonzero
- err_cnt  out  16  saturating count of errored words handed off

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0, out_inst=0, out_err=0, out_err_code=0, err_cnt=0.
  - Address counter = BASE_ADDR.
  - An in-flight word is discarded.
- Handshakes:
  - Input accepted when in_valid && in_ready; output handed off when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. Combinational, no dependence on in_valid.
- Pipeline:
  - One registered stage; latency 1 cycle from input acceptance to out_valid.
  - Full throughput of 1 word/cycle while out_ready is held at 1.
  - Accept and handoff in the same cycle: the register reloads and out_valid stays 1.
  - Handoff with no accept: out_valid goes to 0.
  - While stalled (out_valid && !out_ready), out_inst, out_addr, out_err and out_err_code hold stable.
- Format selection by opcode:
  - I-type: 0010011, 0000011, 1100111.
  - S-type: 0100011.
  - B-type: 1100011.
  - J-type: 1101111.
  - U-type: 0110111, 0010111.
  - R-type: 0110011.
  - Any other opcode: error code 1, out_inst=0.
- Encoding (bits [6:0] = opcode in all formats):
  - I: imm[11:0], rs1, funct3, rd.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0].
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11].
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd.
  - U: imm[31:12], rd.
  - R: funct7, rs2, rs1, funct3, rd.
- Immediate checks (first failing check wins):
  - I and S: in_imm[31:11] must be all 0 or all 1; otherwise code 2.
  - B: in_imm[0] must be 0, otherwise code 3; then in_imm[31:12] must be a uniform sign, otherwise code 2.
  - J: in_imm[0] must be 0, otherwise code 3; then in_imm[31:20] must be a uniform sign, otherwise code 2.
  - U: in_imm[11:0] must be 0, otherwise code 4.
  - R: immediate is ignored.
- Errored words (codes 2–4):
  - Still emitted with fields truncated, out_err=1.
  - They consume an address like any other word.
- Address:
  - out_addr is latched at input acceptance from the counter.
  - The counter increments by 4 per accepted input and wraps modulo 2^ADDR_W.
- err_cnt:
  - Increments on the handoff of a word with out_err=1.
  - Saturates at 16'hFFFF.
- clr:
  - When asserted in the same cycle as an accept, the accepted word takes BASE_ADDR and the counter becomes BASE_ADDR+4.
  - When asserted in the same cycle as an errored handoff, err_cnt ends at 0.

Test Plan:
- addi x1,x0,5 (opcode 0010011, rd=1, rs1=0, f3=0, imm=5), out_ready=1 → next cycle out_valid=1, out_inst=0x00500093, out_addr=0x0, out_err=0.
- sw x2,8(x1) followed by beq x0,x0,-4 (imm=0xFFFFFFFC) back-to-back → out_inst 0x0020A423 at address 0x0, then 0xFE000EE3 at address 0x4, one per cycle.
- jal x1 with imm=0x800 → 0x001000EF. jal with imm=3 → out_err=1, code 3. addi with imm=0x800 → code 2. lui x5 with imm=0x12345000 → 0x123452B7. lui with imm=0x12345001 → code 4.
- Opcode 0x7F → out_inst=0, code 1; err_cnt increments only on handoff.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_inst and out_addr stable, counter frozen; out_ready=1 → words drain in order at consecutive addresses.
- rst_n=0 for one cycle with a word held in the stage → out_valid=0, next accepted word at BASE_ADDR. Then clr concurrent with an accept → that word at BASE_ADDR.
